// File: rtl/mdpath_param_if.sv
// Control, memory and status bus between the multi-cycle controller/memory side
// and the mdpath_param datapath.
interface mdpath_param_if;
  logic        MIO_ready;
  logic        IorD;
  logic        IRWrite;
  logic [1:0]  RegDst;
  logic        RegWrite;
  logic [1:0]  MemtoReg;
  logic        ALUSrcA;
  logic [1:0]  ALUSrcB;
  logic [1:0]  PCSource;
  logic        PCWrite;
  logic        PCWriteCond;
  logic        Branch;
  logic [2:0]  ALU_operation;
  logic [31:0] data2CPU;
  logic [31:0] PC_Current;
  logic [31:0] Inst;
  logic [31:0] data_out;
  logic [31:0] M_addr;
  logic        zero;
  logic        overflow;

  modport master (
    output MIO_ready, IorD, IRWrite, RegDst, RegWrite, MemtoReg, ALUSrcA, ALUSrcB,
           PCSource, PCWrite, PCWriteCond, Branch, ALU_operation, data2CPU,
    input  PC_Current, Inst, data_out, M_addr, zero, overflow
  );

  modport slave (
    input  MIO_ready, IorD, IRWrite, RegDst, RegWrite, MemtoReg, ALUSrcA, ALUSrcB,
           PCSource, PCWrite, PCWriteCond, Branch, ALU_operation, data2CPU,
    output PC_Current, Inst, data_out, M_addr, zero, overflow
  );
endinterface

// File: rtl/mdpath_param.sv
// Parametrised multi-cycle MIPS datapath: PC/IR/MDR/A/B/ALUOut state, 32x32
// register file and 8-op ALU, all state frozen while the memory is not ready.
module mdpath_param #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter bit          SLT_SIGNED = 1'b1
) (
  input logic         clk,
  input logic         reset,
  mdpath_param_if.slave bus
);

  typedef enum logic [2:0] {
    ALU_AND = 3'b000,
    ALU_OR  = 3'b001,
    ALU_ADD = 3'b010,
    ALU_XOR = 3'b011,
    ALU_NOR = 3'b100,
    ALU_SRL = 3'b101,
    ALU_SUB = 3'b110,
    ALU_SLT = 3'b111
  } alu_op_t;

  logic [31:0] pc, ir, mdr, a, b, alu_out;
  logic [31:0] rf [32];

  logic [31:0] rs_data, rt_data;
  logic [31:0] imm_ext;
  logic [31:0] src_a, src_b;
  logic [31:0] alu_res;
  logic        alu_ovf;
  logic        slt_lt;
  logic [31:0] pc_next;
  logic        pc_load;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic        wr_en;
  alu_op_t     op;

  assign op      = alu_op_t'(bus.ALU_operation);
  assign rs_data = (ir[25:21] == 5'd0) ? '0 : rf[ir[25:21]];
  assign rt_data = (ir[20:16] == 5'd0) ? '0 : rf[ir[20:16]];
  assign imm_ext = {{16{ir[15]}}, ir[15:0]};
  assign src_a   = bus.ALUSrcA ? a : pc;

  always_comb begin
    src_b = b;
    case (bus.ALUSrcB)
      2'b00: src_b = b;
      2'b01: src_b = 32'd4;
      2'b10: src_b = imm_ext;
      2'b11: src_b = {imm_ext[29:0], 2'b00};
      default: src_b = b;
    endcase
  end

  assign slt_lt = SLT_SIGNED ? ($signed(src_a) < $signed(src_b)) : (src_a < src_b);

  always_comb begin
    alu_res = '0;
    alu_ovf = 1'b0;
    case (op)
      ALU_AND: alu_res = src_a & src_b;
      ALU_OR:  alu_res = src_a | src_b;
      ALU_ADD: begin
        alu_res = src_a + src_b;
        alu_ovf = (src_a[31] == src_b[31]) && (alu_res[31] != src_a[31]);
      end
      ALU_XOR: alu_res = src_a ^ src_b;
      ALU_NOR: alu_res = ~(src_a | src_b);
      ALU_SRL: alu_res = src_b >> src_a[4:0];
      ALU_SUB: begin
        alu_res = src_a + ~src_b + 32'd1;
        alu_ovf = (src_a[31] != src_b[31]) && (alu_res[31] != src_a[31]);
      end
      ALU_SLT: alu_res = {31'd0, slt_lt};
      default: alu_res = '0;
    endcase
  end

  assign bus.zero     = (alu_res == '0);
  assign bus.overflow = alu_ovf;

  // Branch sense flips the zero test: beq takes on zero, bne on non-zero.
  assign pc_load = bus.PCWrite | (bus.PCWriteCond & (bus.zero ^ bus.Branch));

  always_comb begin
    pc_next = alu_res;
    case (bus.PCSource)
      2'b00: pc_next = alu_res;
      2'b01: pc_next = alu_out;
      2'b10: pc_next = {pc[31:28], ir[25:0], 2'b00};
      2'b11: pc_next = a;
      default: pc_next = alu_res;
    endcase
  end

  always_comb begin
    wr_addr = ir[20:16];
    case (bus.RegDst)
      2'b00: wr_addr = ir[20:16];
      2'b01: wr_addr = ir[15:11];
      2'b10: wr_addr = 5'd31;
      default: wr_addr = 5'd0;
    endcase
  end

  always_comb begin
    wr_data = alu_out;
    case (bus.MemtoReg)
      2'b00: wr_data = alu_out;
      2'b01: wr_data = mdr;
      2'b10: wr_data = {ir[15:0], 16'h0000};
      2'b11: wr_data = pc;
      default: wr_data = alu_out;
    endcase
  end

  assign wr_en = bus.RegWrite && (bus.RegDst != 2'b11) && (wr_addr != 5'd0);

  always_ff @(posedge clk) begin
    if (reset) begin
      pc      <= RESET_PC;
      ir      <= '0;
      mdr     <= '0;
      a       <= '0;
      b       <= '0;
      alu_out <= '0;
      for (int unsigned i = 0; i < 32; i++) rf[i] <= '0;
    end else if (bus.MIO_ready) begin
      if (pc_load)     pc <= pc_next;
      if (bus.IRWrite) ir <= bus.data2CPU;
      mdr     <= bus.data2CPU;
      a       <= rs_data;
      b       <= rt_data;
      alu_out <= alu_res;
      if (wr_en) rf[wr_addr] <= wr_data;
    end
  end

  assign bus.PC_Current = pc;
  assign bus.Inst       = ir;
  assign bus.data_out   = b;
  assign bus.M_addr     = bus.IorD ? alu_out : pc;

endmodule

// File: tb/tb_mdpath_param.sv
// Self-checking bench for mdpath_param: cycle model compared every cycle plus
// hand-computed expectations for fetch, branches, stall, jal/jr and ALU corners.
module tb_mdpath_param;
  localparam logic [31:0] RPC = 32'h0000_3000;

  logic clk = 1'b0;
  logic reset;
  int   tests = 0;
  int   fails = 0;
  bit   check_en = 1'b0;

  mdpath_param_if bus ();
  mdpath_param_if bus2 ();

  mdpath_param #(.RESET_PC(RPC), .SLT_SIGNED(1'b1)) dut (
    .clk(clk), .reset(reset), .bus(bus.slave));
  mdpath_param #(.RESET_PC(RPC), .SLT_SIGNED(1'b0)) dut_u (
    .clk(clk), .reset(reset), .bus(bus2.slave));

  assign bus2.MIO_ready     = bus.MIO_ready;
  assign bus2.IorD          = bus.IorD;
  assign bus2.IRWrite       = bus.IRWrite;
  assign bus2.RegDst        = bus.RegDst;
  assign bus2.RegWrite      = bus.RegWrite;
  assign bus2.MemtoReg      = bus.MemtoReg;
  assign bus2.ALUSrcA       = bus.ALUSrcA;
  assign bus2.ALUSrcB       = bus.ALUSrcB;
  assign bus2.PCSource      = bus.PCSource;
  assign bus2.PCWrite       = bus.PCWrite;
  assign bus2.PCWriteCond   = bus.PCWriteCond;
  assign bus2.Branch        = bus.Branch;
  assign bus2.ALU_operation = bus.ALU_operation;
  assign bus2.data2CPU      = bus.data2CPU;

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [31:0] m_pc, m_ir, m_mdr, m_a, m_b, m_aluout;
  logic [31:0] m_rf [32];

  // Returns {overflow, result}; overflow is judged by exact wide arithmetic.
  function automatic logic [32:0] f_alu(input logic [31:0] x, input logic [31:0] y,
                                        input logic [2:0] op);
    logic [31:0] res;
    longint      sx, sy, wide;
    bit          ovf;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    ovf = 1'b0;
    case (op)
      3'd0: res = x & y;
      3'd1: res = x | y;
      3'd2: begin res = x + y; wide = sx + sy; ovf = (wide != longint'($signed(res))); end
      3'd3: res = x ^ y;
      3'd4: res = ~(x | y);
      3'd5: res = y >> x[4:0];
      3'd6: begin res = x - y; wide = sx - sy; ovf = (wide != longint'($signed(res))); end
      default: res = (sx < sy) ? 32'd1 : 32'd0;
    endcase
    return {ovf, res};
  endfunction

  function automatic logic [31:0] m_opa();
    return bus.ALUSrcA ? m_a : m_pc;
  endfunction

  function automatic logic [31:0] m_opb();
    logic [31:0] sx;
    sx = {{16{m_ir[15]}}, m_ir[15:0]};
    case (bus.ALUSrcB)
      2'd0: return m_b;
      2'd1: return 32'd4;
      2'd2: return sx;
      default: return sx * 4;
    endcase
  endfunction

  logic [32:0] mr;
  logic [31:0] n_pc, n_wd, n_ra, n_rb;
  int          n_wa;

  always @(posedge clk) begin
    if (reset) begin
      m_pc = RPC; m_ir = 0; m_mdr = 0; m_a = 0; m_b = 0; m_aluout = 0;
      for (int i = 0; i < 32; i++) m_rf[i] = 0;
    end else if (bus.MIO_ready) begin
      mr   = f_alu(m_opa(), m_opb(), bus.ALU_operation);
      n_ra = m_rf[m_ir[25:21]];
      n_rb = m_rf[m_ir[20:16]];
      case (bus.RegDst)
        2'd0: n_wa = int'(m_ir[20:16]);
        2'd1: n_wa = int'(m_ir[15:11]);
        2'd2: n_wa = 31;
        default: n_wa = -1;
      endcase
      case (bus.MemtoReg)
        2'd0: n_wd = m_aluout;
        2'd1: n_wd = m_mdr;
        2'd2: n_wd = {m_ir[15:0], 16'h0};
        default: n_wd = m_pc;
      endcase
      case (bus.PCSource)
        2'd0: n_pc = mr[31:0];
        2'd1: n_pc = m_aluout;
        2'd2: n_pc = {m_pc[31:28], m_ir[25:0], 2'b00};
        default: n_pc = m_a;
      endcase
      if (bus.PCWrite || (bus.PCWriteCond && ((mr[31:0] == 0) != bus.Branch))) m_pc = n_pc;
      if (bus.RegWrite && n_wa > 0) m_rf[n_wa] = n_wd;
      if (bus.IRWrite) m_ir = bus.data2CPU;
      m_mdr = bus.data2CPU;
      m_a = n_ra;
      m_b = n_rb;
      m_aluout = mr[31:0];
    end
  end

  logic [32:0] cr;
  always @(negedge clk) begin
    if (check_en) begin
      cr = f_alu(m_opa(), m_opb(), bus.ALU_operation);
      check("pc", bus.PC_Current, m_pc);
      check("inst", bus.Inst, m_ir);
      check("data_out", bus.data_out, m_b);
      check("m_addr", bus.M_addr, bus.IorD ? m_aluout : m_pc);
      check("zero", 32'(bus.zero), 32'(cr[31:0] == 0));
      check("overflow", 32'(bus.overflow), 32'(cr[32]));
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.MIO_ready = 1'b1; bus.IorD = 1'b0; bus.IRWrite = 1'b0; bus.RegDst = 2'b11;
    bus.RegWrite = 1'b0; bus.MemtoReg = 2'b00; bus.ALUSrcA = 1'b0; bus.ALUSrcB = 2'b00;
    bus.PCSource = 2'b00; bus.PCWrite = 1'b0; bus.PCWriteCond = 1'b0; bus.Branch = 1'b0;
    bus.ALU_operation = 3'b010; bus.data2CPU = 32'h0;
  endtask

  task automatic fetch(input logic [31:0] instr);
    idle();
    bus.data2CPU = instr; bus.IRWrite = 1'b1; bus.PCWrite = 1'b1; bus.ALUSrcB = 2'b01;
    tick();
  endtask

  task automatic exec_itype(input logic [31:0] instr);
    fetch(instr);
    idle(); tick();
    idle(); bus.ALUSrcA = 1'b1; bus.ALUSrcB = 2'b10; tick();
    idle(); bus.RegDst = 2'b00; bus.RegWrite = 1'b1; bus.MemtoReg = 2'b00; tick();
    idle();
  endtask

  task automatic exec_lui(input logic [31:0] instr);
    fetch(instr);
    idle(); bus.RegDst = 2'b00; bus.MemtoReg = 2'b10; bus.RegWrite = 1'b1; tick();
    idle();
  endtask

  task automatic rtype_exec(input logic [31:0] instr, input logic [2:0] op);
    fetch(instr);
    idle(); tick();
    idle(); bus.ALUSrcA = 1'b1; bus.ALUSrcB = 2'b00; bus.ALU_operation = op; #1;
  endtask

  initial begin
    idle();
    reset = 1'b1;
    tick();
    check_en = 1'b1;
    tick();
    reset = 1'b0; idle(); #1;
    check("rst_pc", bus.PC_Current, 32'h3000);
    check("rst_maddr", bus.M_addr, 32'h3000);
    check("rst_inst", bus.Inst, 32'h0);
    check("rst_dout", bus.data_out, 32'h0);

    exec_itype(32'h2008_0005);           // addi r8,r0,5
    tick(); #1;
    check("fetch_inst", bus.Inst, 32'h2008_0005);
    check("fetch_pc", bus.PC_Current, 32'h3004);
    check("r8", bus.data_out, 32'd5);

    exec_itype(32'h2001_0007);           // r1 = 7, PC 3008
    exec_itype(32'h2002_0007);           // r2 = 7, PC 300C

    fetch(32'h1022_0004);                // beq r1,r2,+4 -> PC 3010
    idle(); bus.ALUSrcB = 2'b11; tick(); // ALUOut = 3010 + 16
    idle(); bus.ALUSrcA = 1'b1; bus.ALU_operation = 3'b110; bus.PCWriteCond = 1'b1;
    bus.PCSource = 2'b01; #1;
    check("beq_zero", 32'(bus.zero), 32'd1);
    tick(); idle(); #1;
    check("beq_taken_pc", bus.PC_Current, 32'h3020);

    fetch(32'h1422_0004);                // bne r1,r2,+4 -> PC 3024
    idle(); bus.ALUSrcB = 2'b11; tick();
    idle(); bus.ALUSrcA = 1'b1; bus.ALU_operation = 3'b110; bus.PCWriteCond = 1'b1;
    bus.PCSource = 2'b01; bus.Branch = 1'b1; tick();
    idle(); #1;
    check("bne_not_taken_pc", bus.PC_Current, 32'h3024);

    // Stall with fetch and a register write pending (would clobber r2).
    idle(); bus.MIO_ready = 1'b0; bus.data2CPU = 32'h0C00_0040; bus.IRWrite = 1'b1;
    bus.PCWrite = 1'b1; bus.ALUSrcB = 2'b01; bus.RegDst = 2'b00; bus.RegWrite = 1'b1;
    bus.MemtoReg = 2'b11;
    for (int i = 0; i < 3; i++) tick();
    check("stall_pc", bus.PC_Current, 32'h3024);
    check("stall_inst", bus.Inst, 32'h1422_0004);
    bus.MIO_ready = 1'b1; bus.RegWrite = 1'b0; bus.RegDst = 2'b11;
    tick(); #1;
    check("release_pc", bus.PC_Current, 32'h3028);
    check("release_inst", bus.Inst, 32'h0C00_0040);
    check("stall_r2", bus.data_out, 32'd7);

    idle(); bus.RegDst = 2'b10; bus.MemtoReg = 2'b11; bus.RegWrite = 1'b1;
    bus.PCWrite = 1'b1; bus.PCSource = 2'b10; tick();
    idle(); #1;
    check("jal_pc", bus.PC_Current, 32'h0000_0100);

    fetch(32'h03E0_0008);                // jr r31
    idle(); tick();
    idle(); bus.PCSource = 2'b11; bus.PCWrite = 1'b1; tick();
    idle(); #1;
    check("jr_pc", bus.PC_Current, 32'h3028);

    exec_lui(32'h3C03_8000);             // r3 = 8000_0000
    exec_itype(32'h2063_FFFF);           // r3 = 7FFF_FFFF
    exec_itype(32'h2005_0001);           // r5 = 1
    exec_itype(32'h2007_FFFF);           // r7 = -1
    exec_lui(32'h3C04_ABCD);             // r4 = ABCD_0000
    exec_itype(32'h2000_0009);           // write to r0, discarded

    rtype_exec(32'h0065_3020, 3'b010);   // add r3,r5
    check("add_ovf", 32'(bus.overflow), 32'd1);
    tick(); idle(); bus.IorD = 1'b1; #1;
    check("add_res", bus.M_addr, 32'h8000_0000);

    rtype_exec(32'h0005_3022, 3'b110);   // sub r0,r5
    check("sub_ovf", 32'(bus.overflow), 32'd0);
    tick(); idle(); bus.IorD = 1'b1; #1;
    check("sub_res", bus.M_addr, 32'hFFFF_FFFF);

    rtype_exec(32'h00E5_302A, 3'b111);   // slt r7(-1), r5(1)
    check("slt_s_zero", 32'(bus.zero), 32'd0);
    check("slt_u_zero", 32'(bus2.zero), 32'd1);
    tick(); idle(); bus.IorD = 1'b1; #1;
    check("slt_signed", bus.M_addr, 32'd1);
    check("slt_unsigned", bus2.M_addr, 32'd0);

    fetch(32'h0004_2020); idle(); tick(); #1;
    check("lui_r4", bus.data_out, 32'hABCD_0000);
    fetch(32'h0000_2020); idle(); tick(); #1;
    check("r0_zero", bus.data_out, 32'h0);

    idle(); bus.PCWrite = 1'b1; bus.PCWriteCond = 1'b1; bus.ALUSrcB = 2'b01; tick();
    idle(); #1;
    check("both_pc_writes", bus.PC_Current, 32'h3058);

    // Reset wins over stall and pending writes.
    idle(); reset = 1'b1; bus.MIO_ready = 1'b0; bus.RegWrite = 1'b1; bus.RegDst = 2'b01;
    bus.PCWrite = 1'b1; bus.IRWrite = 1'b1; bus.data2CPU = 32'hFFFF_FFFF;
    tick();
    reset = 1'b0; idle(); #1;
    check("mid_rst_pc", bus.PC_Current, 32'h3000);
    check("mid_rst_inst", bus.Inst, 32'h0);
    check("mid_rst_dout", bus.data_out, 32'h0);
    fetch(32'h0004_2020); idle(); tick(); #1;
    check("rst_r4_cleared", bus.data_out, 32'h0);
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
